// File: rtl/pool_fmap_buffer_if.sv
// Stream bundle around the pooled feature-map buffer: valid-only pixel input
// and a single-word valid/ready flattened output.
interface pool_fmap_buffer_if #(
  parameter int unsigned CONV_BIT = 12
);
  logic                       valid_in;
  logic signed [CONV_BIT-1:0] data_in_1;
  logic signed [CONV_BIT-1:0] data_in_2;
  logic signed [CONV_BIT-1:0] data_in_3;
  logic signed [CONV_BIT-1:0] out_data;
  logic                       out_valid;
  logic                       out_ready;
  logic                       out_last;
  logic                       overflow;

  modport master (
    output valid_in, data_in_1, data_in_2, data_in_3, out_ready,
    input  out_data, out_valid, out_last, overflow
  );

  modport slave (
    input  valid_in, data_in_1, data_in_2, data_in_3, out_ready,
    output out_data, out_valid, out_last, overflow
  );
endinterface

// File: rtl/pool_fmap_buffer.sv
// Two-bank ping-pong buffer: captures a 3-channel pooled frame from a raster
// stream and replays it in (ch, y, x) order as a valid/ready word stream.
module pool_fmap_buffer #(
  parameter int unsigned CONV_BIT   = 12,
  parameter int unsigned OUT_WIDTH  = 6,
  parameter int unsigned OUT_HEIGHT = 6
) (
  input logic               clk,
  input logic               rst_n,
  pool_fmap_buffer_if.slave bus
);

  localparam int unsigned PIX   = OUT_WIDTH * OUT_HEIGHT;
  localparam int unsigned PIX_W = (PIX > 1) ? $clog2(PIX) : 1;

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_DRAINING
  } bank_st_t;

  typedef enum logic {
    RD_IDLE,
    RD_DRAIN
  } rd_st_t;

  // Storage: one array per channel, indexed [bank][pixel]; contents are not reset
  logic signed [CONV_BIT-1:0] r_mem_c1 [2][PIX];
  logic signed [CONV_BIT-1:0] r_mem_c2 [2][PIX];
  logic signed [CONV_BIT-1:0] r_mem_c3 [2][PIX];

  bank_st_t                   r_bank_st [2];
  logic                       r_wr_bank;
  logic [PIX_W-1:0]           r_wr_idx;
  rd_st_t                     r_rd_st;
  logic                       r_rd_bank;
  // Read index kept split as channel and in-channel address of the word in the output register
  logic [1:0]                 r_rd_ch;
  logic [PIX_W-1:0]           r_rd_addr;
  logic signed [CONV_BIT-1:0] r_out_data;
  logic                       r_out_valid;
  logic                       r_out_last;
  logic                       r_overflow;

  bank_st_t                   w_bank_st_nxt [2];
  logic                       w_wr_bank_nxt;
  logic [PIX_W-1:0]           w_wr_idx_nxt;
  rd_st_t                     w_rd_st_nxt;
  logic                       w_rd_bank_nxt;
  logic [1:0]                 w_rd_ch_nxt;
  logic [PIX_W-1:0]           w_rd_addr_nxt;
  logic signed [CONV_BIT-1:0] w_out_data_nxt;
  logic                       w_out_valid_nxt;
  logic                       w_out_last_nxt;
  logic                       w_overflow_nxt;

  logic                       w_fire_last;
  logic                       w_writable;
  logic                       w_wr_en;
  logic                       w_ld;
  logic [1:0]                 w_ld_ch;
  logic [PIX_W-1:0]           w_ld_addr;
  logic signed [CONV_BIT-1:0] w_rd_word;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bank_st[0] <= BANK_EMPTY;
      r_bank_st[1] <= BANK_EMPTY;
      r_wr_bank    <= 1'b0;
      r_wr_idx     <= '0;
      r_rd_st      <= RD_IDLE;
      r_rd_bank    <= 1'b0;
      r_rd_ch      <= 2'd0;
      r_rd_addr    <= '0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_bank_st[0] <= w_bank_st_nxt[0];
      r_bank_st[1] <= w_bank_st_nxt[1];
      r_wr_bank    <= w_wr_bank_nxt;
      r_wr_idx     <= w_wr_idx_nxt;
      r_rd_st      <= w_rd_st_nxt;
      r_rd_bank    <= w_rd_bank_nxt;
      r_rd_ch      <= w_rd_ch_nxt;
      r_rd_addr    <= w_rd_addr_nxt;
      r_out_data   <= w_out_data_nxt;
      r_out_valid  <= w_out_valid_nxt;
      r_out_last   <= w_out_last_nxt;
      r_overflow   <= w_overflow_nxt;
    end
  end

  // Pixel write port
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem_c1[r_wr_bank][r_wr_idx] <= bus.data_in_1;
      r_mem_c2[r_wr_bank][r_wr_idx] <= bus.data_in_2;
      r_mem_c3[r_wr_bank][r_wr_idx] <= bus.data_in_3;
    end
  end

  // Word fetch for the output register
  always_comb begin
    w_rd_word = '0;
    case (w_ld_ch)
      2'd0:    w_rd_word = r_mem_c1[r_rd_bank][w_ld_addr];
      2'd1:    w_rd_word = r_mem_c2[r_rd_bank][w_ld_addr];
      default: w_rd_word = r_mem_c3[r_rd_bank][w_ld_addr];
    endcase
  end

  // Next-state: reader first, then writer so a same-edge free is seen as writable
  always_comb begin
    w_bank_st_nxt   = r_bank_st;
    w_wr_bank_nxt   = r_wr_bank;
    w_wr_idx_nxt    = r_wr_idx;
    w_rd_st_nxt     = r_rd_st;
    w_rd_bank_nxt   = r_rd_bank;
    w_rd_ch_nxt     = r_rd_ch;
    w_rd_addr_nxt   = r_rd_addr;
    w_out_data_nxt  = r_out_data;
    w_out_valid_nxt = r_out_valid;
    w_out_last_nxt  = r_out_last;
    w_overflow_nxt  = r_overflow;
    w_wr_en         = 1'b0;
    w_ld            = 1'b0;
    w_ld_ch         = r_rd_ch;
    w_ld_addr       = r_rd_addr;

    w_fire_last = (r_rd_st == RD_DRAIN) && r_out_valid && bus.out_ready &&
                  (r_rd_ch == 2'd2) && (r_rd_addr == PIX_W'(PIX - 1));

    case (r_rd_st)
      RD_IDLE: begin
        if (r_bank_st[r_rd_bank] == BANK_FULL) begin
          w_bank_st_nxt[r_rd_bank] = BANK_DRAINING;
          w_ld                     = 1'b1;
          w_ld_ch                  = 2'd0;
          w_ld_addr                = '0;
          w_rd_st_nxt              = RD_DRAIN;
        end
      end
      RD_DRAIN: begin
        if (w_fire_last) begin
          w_bank_st_nxt[r_rd_bank] = BANK_EMPTY;
          w_rd_bank_nxt            = ~r_rd_bank;
          w_rd_st_nxt              = RD_IDLE;
          w_out_valid_nxt          = 1'b0;
          w_out_last_nxt           = 1'b0;
        end else if (!r_out_valid || bus.out_ready) begin
          w_ld = 1'b1;
          if (r_rd_addr == PIX_W'(PIX - 1)) begin
            w_ld_addr = '0;
            w_ld_ch   = r_rd_ch + 2'd1;
          end else begin
            w_ld_addr = r_rd_addr + PIX_W'(1);
          end
        end
      end
      default: w_rd_st_nxt = RD_IDLE;
    endcase

    if (w_ld) begin
      w_rd_ch_nxt     = w_ld_ch;
      w_rd_addr_nxt   = w_ld_addr;
      w_out_data_nxt  = w_rd_word;
      w_out_valid_nxt = 1'b1;
      w_out_last_nxt  = (w_ld_ch == 2'd2) && (w_ld_addr == PIX_W'(PIX - 1));
    end

    w_writable = (r_bank_st[r_wr_bank] == BANK_EMPTY) ||
                 (r_bank_st[r_wr_bank] == BANK_FILLING) ||
                 (w_fire_last && (r_rd_bank == r_wr_bank));

    if (bus.valid_in) begin
      if (w_writable) begin
        w_wr_en = 1'b1;
        if (r_wr_idx == PIX_W'(PIX - 1)) begin
          w_bank_st_nxt[r_wr_bank] = BANK_FULL;
          w_wr_idx_nxt             = '0;
          w_wr_bank_nxt            = ~r_wr_bank;
        end else begin
          w_bank_st_nxt[r_wr_bank] = BANK_FILLING;
          w_wr_idx_nxt             = r_wr_idx + PIX_W'(1);
        end
      end else begin
        w_overflow_nxt = 1'b1;
      end
    end
  end

  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.out_last  = r_out_last;
  assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_pool_fmap_buffer.sv
// Directed bench for pool_fmap_buffer: scenario table for frame/backpressure/
// ping-pong/overflow runs plus hand-written same-edge-free and reset sequences.
module tb_pool_fmap_buffer;

  localparam int PIXN  = 36;
  localparam int WORDN = 3 * PIXN;

  logic clk = 1'b0;
  logic rst_n;

  pool_fmap_buffer_if #(.CONV_BIT(12)) bus ();

  pool_fmap_buffer #(
    .CONV_BIT  (12),
    .OUT_WIDTH (6),
    .OUT_HEIGHT(6)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [11:0] data;
    logic               last;
  } exp_t;

  typedef struct {
    string    name;
    int       nf;       // frames driven on valid_in, back-to-back
    logic [3:0] pat;    // out_ready pattern, bit = cycle % 4
    bit       hold;     // keep out_ready low while input is sent
    int       expf;     // frames expected at the output
    int       ovf_pix;  // pixel whose edge sets overflow, -1 for none
    int       bubbles;  // out_valid-low cycles between first word and last handshake
    bit       chk_lat;  // check first out_valid cycle
  } scen_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   got   = 0;

  logic               o_valid, o_last, o_ovf;
  logic signed [11:0] o_data;

  function automatic logic signed [11:0] pix(input int f, input int ch, input int k);
    int b;
    b = k + 200 * f;
    case (ch)
      0:       return 12'(b);
      1:       return 12'(100 + b);
      default: return 12'(-b);
    endcase
  endfunction

  task automatic check(input string nm, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic observe();
    o_valid = bus.out_valid;
    o_last  = bus.out_last;
    o_data  = bus.out_data;
    o_ovf   = bus.overflow;
  endtask

  task automatic push_frame(input int f);
    exp_t e;
    for (int ch = 0; ch < 3; ch++)
      for (int k = 0; k < PIXN; k++) begin
        e.data = pix(f, ch, k);
        e.last = (ch == 2) && (k == PIXN - 1);
        exp_q.push_back(e);
      end
  endtask

  // Drive one cycle, score any handshake at the coming edge, then check stall hold
  task automatic cycle(input logic v, input int f, input int k, input logic rdy);
    logic               stall;
    logic signed [11:0] pd;
    logic               pl;
    exp_t               e;
    bus.valid_in  = v;
    bus.data_in_1 = v ? pix(f, 0, k) : 12'sd0;
    bus.data_in_2 = v ? pix(f, 1, k) : 12'sd0;
    bus.data_in_3 = v ? pix(f, 2, k) : 12'sd0;
    bus.out_ready = rdy;
    stall = o_valid && !rdy;
    pd    = o_data;
    pl    = o_last;
    if (o_valid && rdy) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL extra_word: got data %0d, required no word", o_data);
      end else begin
        e = exp_q.pop_front();
        if (o_data !== e.data) begin
          n_err++;
          $display("FAIL word_data[%0d]: got %0d, required %0d", got, o_data, e.data);
        end
        check("word_last", longint'(o_last), longint'(e.last));
      end
      got++;
    end
    @(posedge clk);
    #1;
    observe();
    if (stall) begin
      check("hold_valid", longint'(o_valid), 1);
      check("hold_data", longint'(o_data), longint'(pd));
      check("hold_last", longint'(o_last), longint'(pl));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, longint'(o_valid), 0);
    check({tag, "_data"}, longint'(o_data), 0);
    check({tag, "_last"}, longint'(o_last), 0);
    check({tag, "_ovf"}, longint'(o_ovf), 0);
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.valid_in  = 1'b0;
    bus.out_ready = 1'b0;
    bus.data_in_1 = '0;
    bus.data_in_2 = '0;
    bus.data_in_3 = '0;
    repeat (2) @(posedge clk);
    #1;
    observe();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    exp_q.delete();
    got = 0;
  endtask

  task automatic run_scen(input scen_t s);
    int total, first_v, bub, i, npix;
    logic rdy;
    do_reset();
    for (int f = 0; f < s.expf; f++) push_frame(f);
    total   = s.expf * WORDN;
    npix    = s.nf * PIXN;
    first_v = -1;
    bub     = 0;
    i       = 0;
    while (got < total && i < 3000) begin
      if (i <= npix + 1)
        check({s.name, "_ovf_track"}, longint'(o_ovf), longint'((s.ovf_pix >= 0) && (i > s.ovf_pix)));
      if (first_v >= 0 && !o_valid) bub++;
      if (first_v < 0 && o_valid) first_v = i;
      rdy = (s.hold && i < npix) ? 1'b0 : s.pat[i % 4];
      cycle(i < npix, i / PIXN, i % PIXN, rdy);
      i++;
    end
    check({s.name, "_word_count"}, got, total);
    if (s.chk_lat) check({s.name, "_first_valid_cycle"}, first_v, 37);
    check({s.name, "_bubbles"}, bub, s.bubbles);
    repeat (3) cycle(1'b0, 0, 0, 1'b1);
    check({s.name, "_idle_valid"}, longint'(o_valid), 0);
    check({s.name, "_final_ovf"}, longint'(o_ovf), longint'(s.ovf_pix >= 0));
  endtask

  scen_t tbl[4];

  initial begin
    int i, inj_k, first_v;
    tbl[0] = '{"single",   1, 4'b1111, 1'b0, 1, -1, 0, 1'b1};
    tbl[1] = '{"backpres", 1, 4'b1001, 1'b0, 1, -1, 0, 1'b1};
    tbl[2] = '{"pingpong", 2, 4'b1111, 1'b0, 2, -1, 1, 1'b0};
    tbl[3] = '{"overflow", 3, 4'b1111, 1'b1, 2, 72, 1, 1'b0};

    for (int t = 0; t < 4; t++) run_scen(tbl[t]);

    // Same-edge free: frame C pixel 0 lands on the handshake edge of frame A's last word
    do_reset();
    push_frame(0); push_frame(1); push_frame(2);
    i = 0; inj_k = 0;
    while (got < 3 * WORDN && i < 3000) begin
      if (inj_k == 1) check("same_edge_ovf_after_inject", longint'(o_ovf), 0);
      if (i < 2 * PIXN) begin
        cycle(1'b1, i / PIXN, i % PIXN, 1'b1);
      end else if ((inj_k == 0 && o_valid && o_last) || (inj_k > 0 && inj_k < PIXN)) begin
        cycle(1'b1, 2, inj_k, 1'b1);
        inj_k++;
      end else begin
        cycle(1'b0, 0, 0, 1'b1);
      end
      i++;
    end
    check("same_edge_injected", inj_k, PIXN);
    check("same_edge_word_count", got, 3 * WORDN);
    check("same_edge_final_ovf", longint'(o_ovf), 0);

    // Reset while word 50 sits in the output register
    do_reset();
    push_frame(0);
    i = 0;
    while (!(got == 50 && o_valid) && i < 3000) begin
      cycle(i < PIXN, 0, i % PIXN, 1'b1);
      i++;
    end
    check("middrain_word50", longint'(o_data), 114);
    rst_n         = 1'b0;
    bus.valid_in  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    observe();
    check_reset_outputs("middrain_rst");
    exp_q.delete();
    got = 0;
    push_frame(1);
    i = 0; first_v = -1;
    while (got < WORDN && i < 3000) begin
      if (first_v < 0 && o_valid) first_v = i;
      cycle(i < PIXN, 1, i % PIXN, 1'b1);
      i++;
    end
    check("middrain_first_valid_cycle", first_v, 37);
    check("middrain_word_count", got, WORDN);
    check("middrain_ovf", longint'(o_ovf), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pool_fmap_buffer.md
# pool_fmap_buffer

Ping-pong feature-map buffer that sits on the output of the 2x2 max-pool/ReLU stage. It captures one pooled frame of three channels, OUT_WIDTH x OUT_HEIGHT pixels each, which arrives as a valid-only raster stream with no backpressure. It then re-serialises the frame in channel-major flatten order (ch, y, x) as a single-word valid/ready stream for the fully-connected stage. Two banks let one frame drain while the next fills.

## Interface
- CONV_BIT, 12: signed sample width.
- OUT_WIDTH, 6: pooled pixels per row.
- OUT_HEIGHT, 6: pooled rows per frame.
- Derived: PIX = OUT_WIDTH*OUT_HEIGHT; WORDS = 3*PIX.

- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- valid_in  in  1  pooled pixel present; no ready is returned.
- data_in_1 / data_in_2 / data_in_3  in  CONV_BIT each  signed channel 1/2/3 pooled values.
- out_data  out  CONV_BIT  signed flattened word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts the word.
- out_last  out  1  high with word WORDS-1 of a frame.
- overflow  out  1  sticky; an input pixel was dropped.

## Operation
- **Bank state.** Each bank is EMPTY, FILLING, FULL or DRAINING. Each bank holds 3 arrays of PIX words.
- **Writer.**
  - Keeps wr_bank and wr_idx (0..PIX-1).
  - On valid_in, if wr_bank is writable, all three channels are stored at wr_idx. Writable means EMPTY, FILLING, or freed on this same edge (see below).
  - wr_idx increments. When wr_idx==PIX-1: the bank becomes FULL, wr_idx goes to 0, and wr_bank toggles.
  - If wr_bank is not writable: the pixel is dropped, wr_idx does not advance, and overflow is set.
- **Reader.**
  - Keeps rd_bank and rd_idx (0..WORDS-1).
  - Has two states: IDLE and DRAIN.
  - IDLE: if rd_bank is FULL, the bank goes to DRAINING and word 0 is loaded.
  - DRAIN: word rd_idx maps to channel rd_idx/PIX at address rd_idx%PIX.
  - The next word is loaded into the output register when !out_valid or out_ready.
  - On the handshake of word WORDS-1, the bank becomes EMPTY, rd_bank toggles, and the reader returns to IDLE.
- **Same-edge free.** A bank being freed by the final read handshake counts as writable on that same edge. The write goes to word 0 while the read is at word WORDS-1, so there is no address conflict.
- **Simultaneous events.** Writer completion and reader completion on the same edge both take effect. Bank states are updated independently per bank.
- **Data path.** Data passes through unmodified: no ReLU, clamping or sign change. Negative and zero values are stored exactly as received.
- **Reset.**
  - Both banks go EMPTY; wr_bank, rd_bank, wr_idx and rd_idx go to 0; the reader goes IDLE.
  - out_data=0, out_valid=0, out_last=0, overflow=0.
  - Array contents are not reset.
  - Reset asserted mid-fill or mid-drain discards the partial frame. The first valid_in after reset lands in bank 0 at index 0.

## Timing
- Write: the pixel sampled at edge E is stored at E.
- Bank FULL: visible after the edge of the final pixel (E_last).
- First output: word 0 is registered at E_last+1, so out_valid is high from that cycle.
- Throughput with out_ready held high: one word per cycle. WORDS consecutive words are followed by one IDLE bubble before the next FULL bank drains.
- Hold rule: while out_valid && !out_ready, out_data and out_last hold stable.
- out_valid never drops without a handshake.
- out_last rises only with word WORDS-1 and clears after its handshake.
- overflow clears only on reset.

## Test plan
- **Single frame.** Input: 36 pixels, data_in_1=k, data_in_2=100+k, data_in_3=-k for k=0..35, out_ready=1. Required:
  - out_valid first high 1 cycle after the 36th valid_in edge.
  - 108 consecutive words: 0..35, then 100..135, then 0,-1..-35.
  - out_last only on the 108th word; overflow=0.
- **Backpressure.** Same frame, out_ready toggling 1,0,0,1 in a repeating pattern. Required:
  - out_data is stable during every stall.
  - The word sequence is identical to the single-frame case; no duplicates or skips.
- **Ping-pong.** Two frames back-to-back, valid_in=1 every cycle, out_ready=1. Required:
  - 216 words in frame order, with one bubble between frames.
  - overflow=0.
- **Overflow.** out_ready=0; send 3 frames. Required:
  - Frames 1 and 2 are stored.
  - The first pixel of frame 3 sets overflow=1; all frame-3 pixels are dropped.
  - After raising out_ready: exactly 216 words, frame 1 then frame 2.
- **Same-edge free.** Frame 2 is FULL in bank 1 and bank 0 is draining. Assert valid_in on the cycle of word 107's handshake. Required: the pixel is stored in bank 0 at index 0, and overflow stays 0.
- **Reset mid-drain.** Assert rst_n=0 for 1 cycle at word 50. Required:
  - The following cycle shows out_valid=0, out_data=0, out_last=0, overflow=0.
  - A new frame then drains from word 0 out of bank 0.
